dbg_responder: RTL and testbench
================================

DBG_RESPONDER -- requirements
Module: dbg_responder

Interface
REQ-001 SHALL have parameter DBGADDRWIDTH, default 7: debug word address width.
REQ-002 SHALL have parameter DBGBADDRWIDTH, default 7: debug bank select width.
REQ-003 SHALL have parameter DBGDATAWIDTH, default 144: debug data width.
REQ-004 SHALL have parameter NUMBANK, default 64: implemented banks; legal bank < NUMBANK.
REQ-005 SHALL have parameter TIMEOUT, default 255: watchdog limit in cycles (used only per REQ-026).
REQ-006 SHALL use one clock and an asynchronous, active-high reset, named as follows:
 clk  in  1  sole clock, all logic on posedge
 rst  in  1  asynchronous active-high reset
REQ-007 SHALL have ports:
 dbg_en  in  1  request strobe, sampled on posedge clk
 dbg_read  in  1  read request qualifier
 dbg_write  in  1  write request qualifier
 dbg_addr  in  DBGADDRWIDTH  word address
 dbg_bank  in  DBGBADDRWIDTH  bank select
 dbg_din  in  DBGDATAWIDTH  write data
 dbg_vld  out  1  one-cycle response pulse (read data or write ack)
 dbg_dout  out  DBGDATAWIDTH  read data, valid with dbg_vld
 mem_req  out  1  bank-array access request, held until mem_gnt
 mem_wr  out  1  1 = write, 0 = read
 mem_bank  out  DBGBADDRWIDTH  bank to memory
 mem_addr  out  DBGADDRWIDTH  address to memory
 mem_wdata  out  DBGDATAWIDTH  write data to memory
 mem_gnt  in  1  memory accepted request this cycle
 mem_rvld  in  1  read data return strobe
 mem_rdata  in  DBGDATAWIDTH  read data
 dbg_busy  out  1  high whenever state != IDLE
 dbg_drop_cnt  out  8  saturating count of dropped requests

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one request outstanding.
REQ-009 SHALL accept a request when dbg_en=1 and (dbg_read|dbg_write)=1 in IDLE or RESP; capture addr/bank/din/op in the accepting cycle.
REQ-010 SHALL treat dbg_read=dbg_write=1 as a read; dbg_en=1 with neither set SHALL be ignored and not counted.
REQ-011 SHALL drop a request arriving in ISSUE or WAIT and increment dbg_drop_cnt, saturating at 255.
REQ-012 Legal bank: SHALL go to ISSUE next cycle, drive mem_req=1 with captured fields until the cycle mem_gnt=1.
REQ-013 Write: on mem_gnt SHALL go to RESP; dbg_vld=1 next cycle, dbg_dout=0 (min latency dbg_en N -> dbg_vld N+2).
REQ-014 Read: on mem_gnt SHALL go to WAIT; on mem_rvld capture mem_rdata, go to RESP (min latency N -> N+3).
REQ-015 mem_rvld outside WAIT SHALL be ignored.
REQ-016 Bank >= NUMBANK: no mem_req; SHALL go directly to RESP; dbg_vld next cycle with dbg_dout=0; write discarded.
REQ-017 RESP SHALL last exactly one cycle with dbg_vld=1; then IDLE, or ISSUE/RESP if a request was accepted that cycle.
REQ-018 dbg_dout SHALL be 0 whenever dbg_vld=0.
REQ-019 mem_* outputs other than mem_req SHALL be 0 when mem_req=0.

Reset
REQ-020 rst SHALL asynchronously force state IDLE and all outputs to 0, including dbg_drop_cnt.
REQ-021 rst mid-transaction SHALL abandon it with no dbg_vld; a late mem_rvld after reset SHALL be ignored.

Configuration
REQ-022 Macro DBG_RESP_TIMEOUT_EN SHALL gate a watchdog.
REQ-023 With it: cycle counter clears on entry to ISSUE and on ISSUE->WAIT.
REQ-024 With it: counter reaching TIMEOUT in ISSUE or WAIT SHALL drop mem_req, go to RESP, return dbg_dout all-ones.
REQ-025 With it: a timed-out access SHALL increment dbg_drop_cnt.
REQ-026 Without it: no counter; ISSUE/WAIT SHALL wait indefinitely; TIMEOUT unused.

Structure
REQ-027 FSM state enum and all-ones timeout pattern SHALL live in shared package dbg_pkg.
REQ-028 Saturating counter SHALL be sub-module dbg_sat_cnt; no other sub-modules.

Verification
REQ-029 Write bank 3 addr 0x15 din 0xA5A5, mem_gnt same cycle as mem_req -> mem_wr=1 with those fields; dbg_vld at N+2, dout=0.
REQ-030 Read bank 3 addr 0x15, gnt at N+1, mem_rvld at N+4 with 0xA5A5 -> dbg_vld at N+5, dout=0xA5A5.
REQ-031 Three dbg_en pulses while in WAIT -> all dropped, dbg_drop_cnt=3; 300 more -> saturates at 255.
REQ-032 Read bank 64 (NUMBANK=64) -> no mem_req; dbg_vld at N+1 with dout=0.
REQ-033 Read, mem_gnt held low: with DBG_RESP_TIMEOUT_EN, dbg_vld after TIMEOUT cycles, dout all-ones; without it, dbg_busy stays 1.
REQ-034 rst asserted in WAIT, then mem_rvld -> no dbg_vld; all outputs 0; dbg_busy=0.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug responder.
// Also holds the all-ones pattern returned by the optional watchdog (DBG_RESP_TIMEOUT_EN).
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dbg_state_e;

  // Wide enough for any supported DBGDATAWIDTH; users slice the low bits.
  localparam int unsigned DBG_PAT_MAXW = 512;
  localparam logic [DBG_PAT_MAXW-1:0] DBG_TIMEOUT_PAT = '1;

  function automatic logic [1:0] dbg_sum2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/dbg_sat_cnt.sv
// Saturating up-counter that can advance by 0, 1, 2 or 3 in a single cycle.
module dbg_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc};
    cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dbg_responder.sv
// Debug-port responder: one outstanding access to the bank array, single-cycle responses.
// Optional watchdog on ISSUE/WAIT enabled by defining DBG_RESP_TIMEOUT_EN.
module dbg_responder
  import dbg_pkg::*;
#(
  parameter int DBGADDRWIDTH  = 7,
  parameter int DBGBADDRWIDTH = 7,
  parameter int DBGDATAWIDTH  = 144,
  parameter int NUMBANK       = 64,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dbg_en,
  input  logic                     dbg_read,
  input  logic                     dbg_write,
  input  logic [DBGADDRWIDTH-1:0]  dbg_addr,
  input  logic [DBGBADDRWIDTH-1:0] dbg_bank,
  input  logic [DBGDATAWIDTH-1:0]  dbg_din,
  output logic                     dbg_vld,
  output logic [DBGDATAWIDTH-1:0]  dbg_dout,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [DBGBADDRWIDTH-1:0] mem_bank,
  output logic [DBGADDRWIDTH-1:0]  mem_addr,
  output logic [DBGDATAWIDTH-1:0]  mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvld,
  input  logic [DBGDATAWIDTH-1:0]  mem_rdata,
  output logic                     dbg_busy,
  output logic [7:0]               dbg_drop_cnt
);

  dbg_state_e state_q, state_d;

  logic                     op_wr_q, op_wr_d;
  logic [DBGBADDRWIDTH-1:0] bank_q, bank_d;
  logic [DBGADDRWIDTH-1:0]  addr_q, addr_d;
  logic [DBGDATAWIDTH-1:0]  wdata_q, wdata_d;
  logic [DBGDATAWIDTH-1:0]  resp_q, resp_d;

  logic       req_valid, req_wr, req_legal;
  logic       drop_req, timeout_hit, timeout_taken;
  logic [1:0] drop_inc;

  always_comb begin
    req_valid = dbg_en & (dbg_read | dbg_write);
    // Read wins when both qualifiers are set.
    req_wr    = dbg_write & ~dbg_read;
    req_legal = 32'(dbg_bank) < 32'(NUMBANK);
  end

  always_comb begin
    state_d       = state_q;
    op_wr_d       = op_wr_q;
    bank_d        = bank_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    resp_d        = resp_q;
    drop_req      = 1'b0;
    timeout_taken = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req_valid) begin
          op_wr_d = req_wr;
          bank_d  = dbg_bank;
          addr_d  = dbg_addr;
          wdata_d = dbg_din;
          resp_d  = '0;
          // Out-of-range banks never reach memory and answer with zero.
          state_d = req_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        drop_req = req_valid;
        if (mem_gnt) begin
          state_d = op_wr_q ? RESP : WAIT;
        end else if (timeout_hit) begin
          state_d       = RESP;
          resp_d        = DBG_TIMEOUT_PAT[DBGDATAWIDTH-1:0];
          timeout_taken = 1'b1;
        end
      end
      WAIT: begin
        drop_req = req_valid;
        if (mem_rvld) begin
          state_d = RESP;
          resp_d  = mem_rdata;
        end else if (timeout_hit) begin
          state_d       = RESP;
          resp_d        = DBG_TIMEOUT_PAT[DBGDATAWIDTH-1:0];
          timeout_taken = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    drop_inc = dbg_sum2(drop_req, timeout_taken);
  end

`ifdef DBG_RESP_TIMEOUT_EN
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q, wd_d;

  always_comb begin
    timeout_hit = ((state_q == ISSUE) || (state_q == WAIT)) && (wd_q == WDW'(TIMEOUT));
    wd_d        = wd_q + WDW'(1);
    if ((state_d == ISSUE) && (state_q != ISSUE)) wd_d = '0;
    else if ((state_q == ISSUE) && (state_d == WAIT)) wd_d = '0;
    else if ((state_q != ISSUE) && (state_q != WAIT)) wd_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Captured request fields are qualified by state, so they need no reset.
  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_d;
    bank_q  <= bank_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    resp_q  <= resp_d;
  end

  dbg_sat_cnt #(.W(8)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .cnt (dbg_drop_cnt)
  );

  always_comb begin
    mem_req   = (state_q == ISSUE);
    mem_wr    = mem_req & op_wr_q;
    mem_bank  = mem_req ? bank_q  : '0;
    mem_addr  = mem_req ? addr_q  : '0;
    mem_wdata = mem_req ? wdata_q : '0;
    dbg_vld   = (state_q == RESP);
    dbg_dout  = dbg_vld ? resp_q : '0;
    dbg_busy  = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dbg_responder.sv
// Bench for dbg_responder: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dbg_responder;

  localparam int AW = 7;
  localparam int BW = 7;
  localparam int DW = 144;
  localparam int NUMBANK = 64;
  localparam int TIMEOUT = 255;
`ifdef DBG_RESP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_RESP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          dbg_en, dbg_read, dbg_write;
  logic [AW-1:0] dbg_addr;
  logic [BW-1:0] dbg_bank;
  logic [DW-1:0] dbg_din;
  logic          dbg_vld;
  logic [DW-1:0] dbg_dout;
  logic          mem_req, mem_wr;
  logic [BW-1:0] mem_bank;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvld;
  logic [DW-1:0] mem_rdata;
  logic          dbg_busy;
  logic [7:0]    dbg_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbg_responder #(
    .DBGADDRWIDTH(AW), .DBGBADDRWIDTH(BW), .DBGDATAWIDTH(DW),
    .NUMBANK(NUMBANK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .dbg_en(dbg_en), .dbg_read(dbg_read), .dbg_write(dbg_write),
    .dbg_addr(dbg_addr), .dbg_bank(dbg_bank), .dbg_din(dbg_din),
    .dbg_vld(dbg_vld), .dbg_dout(dbg_dout),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_bank(mem_bank), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
    .dbg_busy(dbg_busy), .dbg_drop_cnt(dbg_drop_cnt)
  );

  // Transaction-level reference: where the single outstanding request is, what it will answer.
  typedef struct {
    int            ph;
    bit            wr;
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] data;
    int            wd;
    int            drops;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t c);
    mdl_t n;
    int   add;
    bit   req;
    n   = c;
    add = 0;
    req = dbg_en && (dbg_read || dbg_write);
    if (c.ph == PH_IDLE || c.ph == PH_RESP) begin
      n.ph = PH_IDLE;
      if (req) begin
        n.wr   = dbg_write && !dbg_read;
        n.bank = dbg_bank;
        n.addr = dbg_addr;
        n.din  = dbg_din;
        n.data = '0;
        n.wd   = 0;
        n.ph   = (int'(dbg_bank) < NUMBANK) ? PH_ISSUE : PH_RESP;
      end
    end else begin
      if (req) add++;
      if (c.ph == PH_ISSUE && mem_gnt) begin
        n.ph = c.wr ? PH_RESP : PH_WAIT;
        n.wd = 0;
      end else if (c.ph == PH_WAIT && mem_rvld) begin
        n.ph   = PH_RESP;
        n.data = mem_rdata;
      end else if (TO_EN && c.wd == TIMEOUT) begin
        n.ph   = PH_RESP;
        n.data = '1;
        add++;
      end else begin
        n.wd = c.wd + 1;
      end
    end
    n.drops = (c.drops + add > 255) ? 255 : c.drops + add;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{ph: PH_IDLE, wr: 1'b0, bank: '0, addr: '0, din: '0, data: '0, wd: 0, drops: 0};
    else     m <= step(m);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [313:0] act, exp;
    bit           e_req;
    e_req = (m.ph == PH_ISSUE);
    exp = {(m.ph == PH_RESP) ? 1'b1 : 1'b0,
           (m.ph == PH_RESP) ? m.data : {DW{1'b0}},
           e_req, e_req && m.wr,
           e_req ? m.bank : {BW{1'b0}},
           e_req ? m.addr : {AW{1'b0}},
           e_req ? m.din  : {DW{1'b0}},
           (m.ph != PH_IDLE) ? 1'b1 : 1'b0,
           8'(m.drops)};
    act = {dbg_vld, dbg_dout, mem_req, mem_wr, mem_bank, mem_addr, mem_wdata, dbg_busy, dbg_drop_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    dbg_en = 1'b0; dbg_read = 1'b0; dbg_write = 1'b0;
    dbg_addr = '0; dbg_bank = '0; dbg_din = '0;
    mem_gnt = 1'b0; mem_rvld = 1'b0; mem_rdata = '0;
  endtask

  task automatic req_in(input bit rd, input bit wr, input int bank, input int addr, input logic [DW-1:0] din);
    dbg_en = 1'b1; dbg_read = rd; dbg_write = wr;
    dbg_bank = BW'(bank); dbg_addr = AW'(addr); dbg_din = din;
  endtask

  initial begin
    logic [159:0] r;
    int           lat;
    idle_in();
    rst = 1'b1;
    tick(); tick(); smp();
    chk("reset_vld", 160'(dbg_vld), 160'(0));
    chk("reset_busy", 160'(dbg_busy), 160'(0));
    chk("reset_drop", 160'(dbg_drop_cnt), 160'(0));
    chk("reset_req", 160'(mem_req), 160'(0));
    tick(); rst = 1'b0;

    // Write, granted in the first ISSUE cycle.
    tick(); req_in(0, 1, 3, 'h15, DW'(16'hA5A5));
    tick(); idle_in(); mem_gnt = 1'b1; smp();
    chk("wr_mem_req", 160'(mem_req), 160'(1));
    chk("wr_mem_wr", 160'(mem_wr), 160'(1));
    chk("wr_mem_bank", 160'(mem_bank), 160'(3));
    chk("wr_mem_addr", 160'(mem_addr), 160'('h15));
    chk("wr_mem_wdata", 160'(mem_wdata), 160'('hA5A5));
    tick(); mem_gnt = 1'b0; smp();
    chk("wr_vld_n2", 160'(dbg_vld), 160'(1));
    chk("wr_dout_zero", 160'(dbg_dout), 160'(0));
    tick(); smp();
    chk("wr_done_busy", 160'(dbg_busy), 160'(0));

    // Read, grant at N+1, data at N+4.
    tick(); req_in(1, 0, 3, 'h15, '0);
    tick(); idle_in(); mem_gnt = 1'b1; smp();
    chk("rd_mem_req", 160'(mem_req), 160'(1));
    chk("rd_mem_wr", 160'(mem_wr), 160'(0));
    tick(); mem_gnt = 1'b0; smp();
    chk("rd_wait_busy", 160'(dbg_busy), 160'(1));
    tick();
    tick(); mem_rvld = 1'b1; mem_rdata = DW'(16'hA5A5); smp();
    chk("rd_vld_early", 160'(dbg_vld), 160'(0));
    tick(); mem_rvld = 1'b0; mem_rdata = '0; smp();
    chk("rd_vld_n5", 160'(dbg_vld), 160'(1));
    chk("rd_dout", 160'(dbg_dout), 160'('hA5A5));
    tick(); smp();
    chk("rd_done_busy", 160'(dbg_busy), 160'(0));

    // Drops while waiting for read data, then saturation.
    tick(); req_in(1, 0, 3, 1, '0);
    tick(); idle_in(); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; req_in(1, 0, 0, 0, '0);
    tick(); tick();
    tick(); idle_in(); smp();
    chk("drop_cnt_3", 160'(dbg_drop_cnt), 160'(3));
    req_in(1, 1, 5, 5, '0);
    repeat (300) tick();
    idle_in(); smp();
    chk("drop_cnt_sat", 160'(dbg_drop_cnt), 160'(255));
    chk("drop_still_busy", 160'(dbg_busy), 160'(1));
    mem_rvld = 1'b1; mem_rdata = DW'(32'h1234_5678);
    tick(); mem_rvld = 1'b0; smp();
    chk("drop_rd_vld", 160'(dbg_vld), 160'(1));
    chk("drop_rd_dout", 160'(dbg_dout), 160'(32'h1234_5678));
    rst = 1'b1; tick(); rst = 1'b0; smp();
    chk("drop_cnt_cleared", 160'(dbg_drop_cnt), 160'(0));

    // Out-of-range bank answers immediately with zero.
    tick(); req_in(1, 0, 64, 2, '0);
    tick(); idle_in(); smp();
    chk("bad_bank_vld", 160'(dbg_vld), 160'(1));
    chk("bad_bank_req", 160'(mem_req), 160'(0));
    chk("bad_bank_dout", 160'(dbg_dout), 160'(0));
    tick(); smp();
    chk("bad_bank_idle", 160'(dbg_busy), 160'(0));

    // Grant never arrives.
    tick(); req_in(1, 0, 3, 7, '0);
    tick(); idle_in();
`ifdef DBG_RESP_TIMEOUT_EN
    lat = 1; smp();
    while (!dbg_vld && lat < TIMEOUT + 20) begin
      tick(); lat++; smp();
    end
    chk("timeout_latency", 160'(lat), 160'(TIMEOUT + 2));
    chk("timeout_dout", 160'(dbg_dout), {16'h0, {DW{1'b1}}});
    chk("timeout_drop", 160'(dbg_drop_cnt), 160'(1));
    tick();
`else
    lat = 0;
    repeat (TIMEOUT + 20) begin tick(); lat++; end
    smp();
    chk("no_timeout_busy", 160'(dbg_busy), 160'(1));
    chk("no_timeout_req", 160'(mem_req), 160'(1));
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvld = 1'b1; mem_rdata = DW'(8'h3C); tick(); mem_rvld = 1'b0; smp();
    chk("no_timeout_recover", 160'(dbg_dout), 160'(8'h3C));
    tick();
`endif

    // Reset in WAIT abandons the read; late data is ignored.
    tick(); req_in(1, 0, 3, 9, '0);
    tick(); idle_in(); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; smp();
    chk("rst_wait_busy", 160'(dbg_busy), 160'(1));
    tick(); rst = 1'b1; smp();
    chk("rst_busy", 160'(dbg_busy), 160'(0));
    chk("rst_vld", 160'(dbg_vld), 160'(0));
    chk("rst_outs", 160'({mem_req, mem_wr, mem_bank, mem_addr, dbg_drop_cnt}), 160'(0));
    tick(); rst = 1'b0; mem_rvld = 1'b1; mem_rdata = DW'(16'hBEEF);
    tick(); mem_rvld = 1'b0; smp();
    chk("late_rvld_vld", 160'(dbg_vld), 160'(0));
    chk("late_rvld_busy", 160'(dbg_busy), 160'(0));

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst       = ($urandom_range(0, 599) == 0);
      dbg_en    = ($urandom_range(0, 2) == 0);
      dbg_read  = $urandom_range(0, 1) == 1;
      dbg_write = $urandom_range(0, 1) == 1;
      dbg_bank  = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(64, 127)) : BW'($urandom_range(0, 63));
      dbg_addr  = AW'($urandom);
      r         = {$urandom, $urandom, $urandom, $urandom, $urandom};
      dbg_din   = r[DW-1:0];
      mem_gnt   = ($urandom_range(0, 2) == 0);
      mem_rvld  = ($urandom_range(0, 2) == 0);
      r         = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mem_rdata = r[DW-1:0];
    end
    tick(); rst = 1'b0; idle_in();
    repeat (4) tick();
    smp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
